// File: rtl/lsu_ctrl.sv
// Load/store unit controller: decodes RV32I load/store requests, drives a word-wide data memory
// port with byte enables, formats load data and aborts accesses that see no ack in time.
module lsu_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_wen,
   input  logic [2:0]  i_req_funct3,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,

   output logic        o_resp_valid,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_err,
   output logic        o_busy,

   output logic [31:0] o_dmem_addr,
   output logic        o_dmem_ren,
   output logic        o_dmem_wen,
   output logic [31:0] o_dmem_wdata,
   output logic [3:0]  o_dmem_mask,
   input  logic [31:0] i_dmem_rdata,
   input  logic        i_dmem_valid
);

   typedef enum logic [0:0] {StIdle, StAccess} state_e;

   localparam logic [7:0] LastCycle = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;

   logic [31:0] addr_q;
   logic [2:0]  funct3_q;
   logic        wen_q;
   logic [31:0] wdata_q;
   logic [3:0]  mask_q;

   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] rdata_q, rdata_d;

   logic        req_legal;
   logic        req_misaligned;
   logic        req_ok;
   logic [3:0]  req_mask;
   logic [31:0] req_wdata;
   logic        ready;
   logic        accept;
   logic        ack;
   logic        timeout_hit;
   logic        access_act;
   logic [31:0] rdata_shifted;
   logic [31:0] load_data;

   // Request decode
   always_comb begin
      if (i_req_wen) begin
         req_legal = (i_req_funct3 == 3'b000) || (i_req_funct3 == 3'b001) ||
                     (i_req_funct3 == 3'b010);
      end else begin
         req_legal = (i_req_funct3 == 3'b000) || (i_req_funct3 == 3'b001) ||
                     (i_req_funct3 == 3'b010) || (i_req_funct3 == 3'b100) ||
                     (i_req_funct3 == 3'b101);
      end

      req_misaligned = 1'b0;
      req_mask       = 4'b1111;
      req_wdata      = i_req_wdata;
      case (i_req_funct3[1:0])
         2'b00: begin
            req_mask  = 4'b0001 << i_req_addr[1:0];
            req_wdata = {4{i_req_wdata[7:0]}};
         end
         2'b01: begin
            req_misaligned = i_req_addr[0];
            req_mask       = 4'b0011 << i_req_addr[1:0];
            req_wdata      = {2{i_req_wdata[15:0]}};
         end
         default: begin
            req_misaligned = (i_req_addr[1:0] != 2'b00);
            req_mask       = 4'b1111;
            req_wdata      = i_req_wdata;
         end
      endcase

      // Loads never drive write data onto the bus
      if (!i_req_wen) begin
         req_wdata = 32'h0;
      end

      req_ok = req_legal && !req_misaligned;
   end

   assign ready       = (state_q == StIdle) && !rst;
   assign accept      = i_req_valid && ready;
   assign ack         = (state_q == StAccess) && i_dmem_valid;
   assign timeout_hit = (state_q == StAccess) && !i_dmem_valid && (cnt_q == LastCycle);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept && req_ok) begin
               state_d = StAccess;
            end
         end
         StAccess: begin
            if (ack || timeout_hit) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output logic; reset forces every output low in the same cycle
   always_comb begin
      access_act   = (state_q == StAccess) && !rst;
      o_req_ready  = ready;
      o_busy       = access_act;
      o_dmem_ren   = access_act && !wen_q;
      o_dmem_wen   = access_act && wen_q;
      o_dmem_addr  = access_act ? {addr_q[31:2], 2'b00} : 32'h0;
      o_dmem_mask  = access_act ? mask_q : 4'b0000;
      o_dmem_wdata = access_act ? wdata_q : 32'h0;
      o_resp_valid = resp_valid_q && !rst;
      o_resp_err   = resp_err_q && !rst;
      o_resp_rdata = rst ? 32'h0 : rdata_q;
   end

   // Access cycle counter
   always_comb begin
      cnt_d = cnt_q;
      if (accept) begin
         cnt_d = 8'd0;
      end else if (state_q == StAccess) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Captured request
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q   <= 32'h0;
         funct3_q <= 3'b000;
         wen_q    <= 1'b0;
         wdata_q  <= 32'h0;
         mask_q   <= 4'b0000;
      end else if (accept) begin
         addr_q   <= i_req_addr;
         funct3_q <= i_req_funct3;
         wen_q    <= i_req_wen;
         wdata_q  <= req_wdata;
         mask_q   <= req_mask;
      end
   end

   // Load data formatting
   always_comb begin
      rdata_shifted = i_dmem_rdata >> {addr_q[1:0], 3'b000};
      case (funct3_q)
         3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
         3'b001:  load_data = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
         3'b010:  load_data = i_dmem_rdata;
         3'b100:  load_data = {24'h0, rdata_shifted[7:0]};
         3'b101:  load_data = {16'h0, rdata_shifted[15:0]};
         default: load_data = 32'h0;
      endcase
   end

   // Response; read data holds until the next response
   always_comb begin
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      rdata_d      = rdata_q;
      if (accept && !req_ok) begin
         resp_valid_d = 1'b1;
         resp_err_d   = 1'b1;
         rdata_d      = 32'h0;
      end else if (ack) begin
         resp_valid_d = 1'b1;
         rdata_d      = wen_q ? 32'h0 : load_data;
      end else if (timeout_hit) begin
         resp_valid_d = 1'b1;
         resp_err_d   = 1'b1;
         rdata_d      = 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         rdata_q      <= 32'h0;
      end else begin
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         rdata_q      <= rdata_d;
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed literal scenarios plus randomized traffic, all checked every cycle
// against a transaction-level model of the controller.
module tb_lsu_ctrl;
   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req_valid;
   logic        o_req_ready;
   logic        i_req_wen;
   logic [2:0]  i_req_funct3;
   logic [31:0] i_req_addr;
   logic [31:0] i_req_wdata;
   logic        o_resp_valid;
   logic [31:0] o_resp_rdata;
   logic        o_resp_err;
   logic        o_busy;
   logic [31:0] o_dmem_addr;
   logic        o_dmem_ren;
   logic        o_dmem_wen;
   logic [31:0] o_dmem_wdata;
   logic [3:0]  o_dmem_mask;
   logic [31:0] i_dmem_rdata;
   logic        i_dmem_valid;

   int checks = 0;
   int errors = 0;

   lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_req_wen    (i_req_wen),
      .i_req_funct3 (i_req_funct3),
      .i_req_addr   (i_req_addr),
      .i_req_wdata  (i_req_wdata),
      .o_resp_valid (o_resp_valid),
      .o_resp_rdata (o_resp_rdata),
      .o_resp_err   (o_resp_err),
      .o_busy       (o_busy),
      .o_dmem_addr  (o_dmem_addr),
      .o_dmem_ren   (o_dmem_ren),
      .o_dmem_wen   (o_dmem_wen),
      .o_dmem_wdata (o_dmem_wdata),
      .o_dmem_mask  (o_dmem_mask),
      .i_dmem_rdata (i_dmem_rdata),
      .i_dmem_valid (i_dmem_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   bit          m_busy = 1'b0;
   int          m_cnt = 0;
   logic [31:0] m_addr = 32'h0;
   logic [31:0] m_wdata = 32'h0;
   logic [2:0]  m_f3 = 3'b000;
   logic        m_wen = 1'b0;
   logic        e_valid = 1'b0;
   logic        e_err = 1'b0;
   logic [31:0] e_rdata = 32'h0;

   function automatic bit req_ok(input logic wen, input logic [2:0] f3, input logic [31:0] a);
      bit legal, mis;
      int unsigned f = int'(f3);
      int unsigned lo = int'(a[1:0]);
      legal = wen ? (f <= 2) : (f == 0 || f == 1 || f == 2 || f == 4 || f == 5);
      mis   = ((f % 4) == 1 && (lo % 2) == 1) || ((f % 4) == 2 && lo != 0);
      return legal && !mis;
   endfunction

   function automatic logic [3:0] mask_of(input logic [2:0] f3, input logic [31:0] a);
      int unsigned lo = int'(a[1:0]);
      case (int'(f3) % 4)
         0:       return 4'((1 << lo) & 15);
         1:       return 4'((3 << lo) & 15);
         default: return 4'd15;
      endcase
   endfunction

   function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] w);
      case (int'(f3) % 4)
         0:       return (w & 32'hFF) * 32'h0101_0101;
         1:       return (w & 32'hFFFF) * 32'h0001_0001;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
      logic [31:0] s;
      longint v;
      s = rd >> (8 * int'(a[1:0]));
      case (int'(f3))
         0: begin v = longint'(s & 32'hFF);   if (v >= 128)   v -= 256;   end
         1: begin v = longint'(s & 32'hFFFF); if (v >= 32768) v -= 65536; end
         4: v = longint'(s & 32'hFF);
         5: v = longint'(s & 32'hFFFF);
         default: v = longint'(rd);
      endcase
      return 32'(v);
   endfunction

   task automatic model_step();
      if (rst) begin
         m_busy  = 1'b0;
         m_cnt   = 0;
         e_valid = 1'b0;
         e_err   = 1'b0;
         e_rdata = 32'h0;
         return;
      end
      e_valid = 1'b0;
      e_err   = 1'b0;
      if (m_busy) begin
         m_cnt++;
         if (i_dmem_valid) begin
            m_busy  = 1'b0;
            e_valid = 1'b1;
            e_rdata = m_wen ? 32'h0 : load_fmt(m_f3, m_addr, i_dmem_rdata);
         end else if (m_cnt == int'(TIMEOUT)) begin
            m_busy  = 1'b0;
            e_valid = 1'b1;
            e_err   = 1'b1;
            e_rdata = 32'h0;
         end
      end else if (i_req_valid) begin
         if (req_ok(i_req_wen, i_req_funct3, i_req_addr)) begin
            m_busy  = 1'b1;
            m_cnt   = 0;
            m_addr  = i_req_addr;
            m_f3    = i_req_funct3;
            m_wen   = i_req_wen;
            m_wdata = i_req_wdata;
         end else begin
            e_valid = 1'b1;
            e_err   = 1'b1;
            e_rdata = 32'h0;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   task automatic compare();
      bit on;
      on = !rst;
      chk("ready", o_req_ready, on && !m_busy);
      chk("busy", o_busy, on && m_busy);
      chk("ren", o_dmem_ren, on && m_busy && !m_wen);
      chk("wen", o_dmem_wen, on && m_busy && m_wen);
      chk("dmem_addr", o_dmem_addr, (on && m_busy) ? (m_addr & 32'hFFFF_FFFC) : 32'h0);
      chk("mask", o_dmem_mask, (on && m_busy) ? mask_of(m_f3, m_addr) : 4'h0);
      chk("wdata", o_dmem_wdata, (on && m_busy && m_wen) ? wdata_of(m_f3, m_wdata) : 32'h0);
      chk("resp_valid", o_resp_valid, on && e_valid);
      chk("resp_err", o_resp_err, on && e_err);
      chk("resp_rdata", o_resp_rdata, on ? e_rdata : 32'h0);
   endtask

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         compare();
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      i_req_valid  = 1'b0;
      i_req_wen    = 1'b0;
      i_req_funct3 = 3'b000;
      i_req_addr   = 32'h0;
      i_req_wdata  = 32'h0;
      i_dmem_valid = 1'b0;
      i_dmem_rdata = 32'h0;
   endtask

   task automatic set_req(input logic wen, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] w);
      i_req_valid  = 1'b1;
      i_req_wen    = wen;
      i_req_funct3 = f3;
      i_req_addr   = a;
      i_req_wdata  = w;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int ack_pct;
      rst          = 1'b1;
      i_req_valid  = 1'b1;
      i_req_wen    = 1'b0;
      i_req_funct3 = 3'b010;
      i_req_addr   = 32'h100;
      i_req_wdata  = 32'h0;
      i_dmem_valid = 1'b1;
      i_dmem_rdata = 32'hDEAD_BEEF;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_ready", o_req_ready, 1'b0);
      chk("rst_ren", o_dmem_ren, 1'b0);
      chk("rst_resp_valid", o_resp_valid, 1'b0);
      tick();
      rst = 1'b0;
      set_idle();
      tick();

      // LB 0x103, ack in first access cycle
      set_req(1'b0, 3'b000, 32'h103, 32'h0);
      @(negedge clk);
      chk("lb_ready", o_req_ready, 1'b1);
      tick();
      set_idle();
      i_dmem_valid = 1'b1;
      i_dmem_rdata = 32'h80FF_FF00;
      @(negedge clk);
      chk("lb_mask", o_dmem_mask, 4'b1000);
      chk("lb_addr", o_dmem_addr, 32'h100);
      chk("lb_ren", o_dmem_ren, 1'b1);
      tick();
      set_idle();
      @(negedge clk);
      chk("lb_valid", o_resp_valid, 1'b1);
      chk("lb_err", o_resp_err, 1'b0);
      chk("lb_rdata", o_resp_rdata, 32'hFFFF_FF80);
      tick();

      // SH 0x202
      set_req(1'b1, 3'b001, 32'h202, 32'h1234_ABCD);
      tick();
      set_idle();
      i_dmem_valid = 1'b1;
      @(negedge clk);
      chk("sh_wen", o_dmem_wen, 1'b1);
      chk("sh_mask", o_dmem_mask, 4'b1100);
      chk("sh_wdata", o_dmem_wdata, 32'hABCD_ABCD);
      tick();
      set_idle();
      @(negedge clk);
      chk("sh_valid", o_resp_valid, 1'b1);
      chk("sh_err", o_resp_err, 1'b0);
      chk("sh_rdata", o_resp_rdata, 32'h0);
      tick();

      // Misaligned LW 0x101
      set_req(1'b0, 3'b010, 32'h101, 32'h0);
      tick();
      set_idle();
      @(negedge clk);
      chk("lwmis_valid", o_resp_valid, 1'b1);
      chk("lwmis_err", o_resp_err, 1'b1);
      chk("lwmis_ren", o_dmem_ren, 1'b0);
      chk("lwmis_ready", o_req_ready, 1'b1);
      tick();
      @(negedge clk);
      chk("lwmis_pulse", o_resp_valid, 1'b0);
      tick();

      // LHU 0x006, ack in fifth access cycle
      set_req(1'b0, 3'b101, 32'h006, 32'h0);
      tick();
      set_idle();
      for (int k = 1; k <= 5; k++) begin
         if (k == 5) begin
            i_dmem_valid = 1'b1;
            i_dmem_rdata = 32'h8001_0000;
         end
         @(negedge clk);
         chk("lhu_ren", o_dmem_ren, 1'b1);
         chk("lhu_mask", o_dmem_mask, 4'b1100);
         chk("lhu_addr", o_dmem_addr, 32'h4);
         tick();
      end
      set_idle();
      @(negedge clk);
      chk("lhu_rdata", o_resp_rdata, 32'h0000_8001);
      chk("lhu_valid", o_resp_valid, 1'b1);
      tick();

      // Timeout, then ack in the final allowed cycle
      for (int pass = 0; pass < 2; pass++) begin
         set_req(1'b0, 3'b010, 32'h40, 32'h0);
         tick();
         set_idle();
         for (int k = 1; k <= 16; k++) begin
            if (pass == 1 && k == 16) begin
               i_dmem_valid = 1'b1;
               i_dmem_rdata = 32'h1234_5678;
            end
            @(negedge clk);
            chk("to_ren", o_dmem_ren, 1'b1);
            tick();
         end
         set_idle();
         @(negedge clk);
         chk("to_valid", o_resp_valid, 1'b1);
         chk("to_err", o_resp_err, (pass == 0) ? 1'b1 : 1'b0);
         chk("to_rdata", o_resp_rdata, (pass == 0) ? 32'h0 : 32'h1234_5678);
         chk("to_ren_off", o_dmem_ren, 1'b0);
         tick();
      end

      // Reset in the second access cycle
      set_req(1'b0, 3'b010, 32'h80, 32'h0);
      tick();
      set_idle();
      @(negedge clk);
      chk("rsta_ren1", o_dmem_ren, 1'b1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rsta_ren", o_dmem_ren, 1'b0);
      chk("rsta_valid", o_resp_valid, 1'b0);
      chk("rsta_ready", o_req_ready, 1'b1);
      tick();
      @(negedge clk);
      chk("rsta_valid2", o_resp_valid, 1'b0);
      tick();

      // Randomized traffic with varying memory responsiveness
      ack_pct = 50;
      for (int c = 0; c < 4000; c++) begin
         if (c % 250 == 0) begin
            case ($urandom_range(3))
               0:       ack_pct = 0;
               1:       ack_pct = 10;
               2:       ack_pct = 50;
               default: ack_pct = 100;
            endcase
         end
         i_req_valid  = ($urandom_range(99) < 50);
         i_req_wen    = 1'($urandom_range(1));
         i_req_funct3 = 3'($urandom_range(7));
         i_req_addr   = $urandom;
         i_req_wdata  = $urandom;
         i_dmem_valid = (int'($urandom_range(99)) < ack_pct);
         i_dmem_rdata = $urandom;
         rst          = ($urandom_range(299) == 0);
         tick();
      end
      rst = 1'b0;
      set_idle();
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
